// File: rtl/core_frame_receiver.sv
// Core-side receiver for the scheduler dispatch protocol: detects activation, fetches a
// framed program into local imem, then holds the core in RUN. Optional macro: CORE_RX_HDR_CHECK_EN.
module core_frame_receiver #(
  parameter int CORE_ID    = 0,
  parameter int IMEM_DEPTH = 512,
  parameter int ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       new_act_core,
  input  logic [15:0]       init_r0_vect,
  input  logic [15:0]       r0_data_in,
  input  logic [31:0]       mess_to_core,
  input  logic              core_done,
  output logic              core_read_f,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [15:0]       r0,
  output logic              busy,
  output logic              running,
  output logic              load_done,
  output logic              core_ready,
  output logic [1:0]        err,
  output logic [2:0]        dbg_state
);

  // Word counter must reach 503 (63 frames of 8 words) even for shallow memories.
  localparam int CNT_W = ($clog2(IMEM_DEPTH) > 9) ? $clog2(IMEM_DEPTH) : 9;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HREQ = 3'd1,
    S_HCAP = 3'd2,
    S_WREQ = 3'd3,
    S_WCAP = 3'd4,
    S_DONE = 3'd5,
    S_RUN  = 3'd6
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             act_q;
  logic             act_edge;
  logic [5:0]       n_q;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] last_word;
  logic             hdr_ok;
  logic             err_ovr;
  logic             err_hdr;
  logic             unused_bits;

  // Fetch handshake: core_read_f is a one-cycle request with no backpressure; the
  // scheduler answers by presenting mess_to_core valid on exactly the next cycle.
  assign act_edge    = new_act_core[CORE_ID] & ~act_q;
  assign last_word   = CNT_W'({n_q, 3'b000} - 9'd1);
  assign unused_bits = ^{new_act_core, init_r0_vect};
  assign err         = {err_hdr, err_ovr};
  assign dbg_state   = state;

`ifdef CORE_RX_HDR_CHECK_EN
  assign hdr_ok = (mess_to_core[31:24] == 8'hA5);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_hdr <= 1'b0;
    end else if (state == S_HCAP && !hdr_ok) begin
      err_hdr <= 1'b1;
    end
  end
`else
  assign hdr_ok  = 1'b1;
  assign err_hdr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (act_edge) state_next = S_HREQ;
      S_HREQ: state_next = S_HCAP;
      S_HCAP: begin
        if (!hdr_ok) begin
          state_next = S_IDLE;
        end else if (mess_to_core[5:0] == 6'd0) begin
          state_next = S_DONE;
        end else begin
          state_next = S_WREQ;
        end
      end
      S_WREQ: state_next = S_WCAP;
      S_WCAP: state_next = (wcnt == last_word) ? S_DONE : S_WREQ;
      S_DONE: state_next = S_RUN;
      S_RUN:  if (core_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    core_read_f = (state == S_HREQ) || (state == S_WREQ);
    busy        = (state != S_IDLE);
    running     = (state == S_RUN);
    load_done   = (state == S_DONE);
  end

  // Datapath: edge detect, r0 latch, word counter, imem write port and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_q      <= 1'b0;
      r0         <= '0;
      err_ovr    <= 1'b0;
      n_q        <= '0;
      wcnt       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_ready <= 1'b0;
    end else begin
      act_q      <= new_act_core[CORE_ID];
      imem_we    <= 1'b0;
      core_ready <= 1'b0;
      if (state == S_IDLE && act_edge && init_r0_vect[CORE_ID]) begin
        r0 <= r0_data_in;
      end
      if (state != S_IDLE && act_edge) begin
        err_ovr <= 1'b1;
      end
      case (state)
        S_HCAP: begin
          n_q  <= mess_to_core[5:0];
          wcnt <= '0;
        end
        S_WCAP: begin
          imem_we    <= 1'b1;
          imem_addr  <= ADDR_W'(wcnt);
          imem_wdata <= mess_to_core;
          wcnt       <= wcnt + 1'b1;
        end
        S_RUN: begin
          if (core_done) core_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
